ps2_keyboard_rx: RTL and testbench
==================================

Name: ps2_keyboard_rx

Overview:
- Upstream stage of the keyboard-to-ASCII/seven-segment path.
- Receives PS/2 device frames on ps2_clk/ps2_data and validates start, stop and odd parity.
- Buffers valid scancodes in a small FIFO and tracks make/break state.
- Presents the current key code and press count to the downstream key lookup mux. That mux is a separate block and consumes cur_key and data.

Parameters:
FIFO_AW, 3, FIFO address width. Depth is 2**FIFO_AW. Usable capacity is 2**FIFO_AW - 1.
TIMEOUT, 20000, clk cycles without a ps2_clk falling edge before a partial frame is discarded.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
ps2_clk  in  1  PS/2 clock from device, asynchronous to clk
ps2_data  in  1  PS/2 data from device, asynchronous to clk
rd_en  in  1  pop request; ignored when ready=0
ovf_clr  in  1  clears overflow
data  out  8  FIFO head scancode; combinational read of the head entry
ready  out  1  FIFO non-empty
overflow  out  1  sticky; a valid frame was dropped because the FIFO was full
frame_err  out  1  one-cycle pulse on a bad frame
cur_key  out  8  last make code received
key_down  out  1  cur_key currently held
press_cnt  out  8  count of distinct key presses; wraps

Behaviour:
Reset values (async, while rst=1): all pointers, counters, shift register, state and outputs are 0. This includes ready, overflow, frame_err, cur_key, key_down and press_cnt. Synchronizers reset to 1 (idle bus). A reset mid-frame discards the partial frame.

Synchronization and sampling:
- ps2_clk passes through a 3-FF shift register s[2:0]; ps2_data passes through a 2-FF synchronizer.
- A sample event is s[2]=1 and s[1]=0 (falling edge). On that event the synchronized data bit is captured.

Frame capture:
- 4-bit bit counter, 0..10. Each sample event shifts the captured bit into buf[bit_cnt] and increments the counter.
- On the sample event with bit_cnt=10, the counter returns to 0 and the frame is checked:
  - buf[0] must be 0 (start).
  - ps2_data must be 1 (stop).
  - XOR of buf[9:1] must be 1 (odd parity).
- Valid frame: code = buf[8:1] goes to the FIFO write and the key tracker on the next cycle.
- Invalid frame: frame_err=1 for exactly one cycle. No push, no tracker update.
- Timeout: an idle counter counts cycles since the last sample event while bit_cnt != 0. When it reaches TIMEOUT, bit_cnt resets to 0 silently.

FIFO:
- Storage is 2**FIFO_AW x 8 bits, with wrapping write pointer w_ptr and read pointer r_ptr.
- ready = (w_ptr != r_ptr). full = (w_ptr+1 == r_ptr).
- data = mem[r_ptr] combinationally. data is undefined/don't-care when ready=0.
- Push of a valid code: if not full, write mem[w_ptr] and increment w_ptr. ready rises the cycle after the push.
- Push when full: the code is dropped and overflow is set to 1.
- Pop: rd_en=1 with ready=1 increments r_ptr at the clock edge.
- Simultaneous push and pop: full is evaluated on pre-pop pointers, so a push while full is dropped even with a concurrent pop. Otherwise both take effect.
- overflow clears only on ovf_clr=1 or reset. If a set and a clear coincide, the set wins.

Key tracker FSM (states IDLE, BREAK), driven by every valid code whether or not the FIFO accepted it:
- IDLE, code=0xF0: go to BREAK.
- IDLE, code=0xE0: no change.
- IDLE, any other code: cur_key<=code and key_down<=1.
  - press_cnt increments only if key_down=0 or code != cur_key. Typematic repeats are not counted.
  - press_cnt wraps from 255 to 0.
- BREAK, code=0xE0: stay in BREAK.
- BREAK, any other code: if code==cur_key then key_down<=0. cur_key is retained. Return to IDLE.
- Tracker outputs update on the same edge as the FIFO write.

Test Plan:
- Single frame 0x1C with correct parity -> ready=1 one cycle after the write, data=0x1C, cur_key=0x1C, key_down=1, press_cnt=1. rd_en=1 -> ready=0.
- Frames 0x1C, 0x1C, 0x1C, 0xF0, 0x1C -> press_cnt=1, key_down=0 at the end, cur_key=0x1C, FIFO holds 5 entries read out in order.
- Frame 0x1C with a flipped parity bit, then a frame with stop bit 0 -> two frame_err single-cycle pulses, ready stays 0, tracker unchanged.
- 8 valid frames 0x01..0x08 with no reads (FIFO_AW=3) -> 7 stored, overflow=1. Reads return 0x01..0x07. ovf_clr -> overflow=0.
- 5 bits of a frame, then TIMEOUT+5 idle cycles, then a full frame 0x32 -> data=0x32, frame_err never asserted.
- rst asserted after 6 bits of a frame -> all outputs 0 immediately (asynchronously). After release, frame 0x45 -> data=0x45, press_cnt=1.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver.
// Samples device frames on ps2_clk/ps2_data, checks start/stop/odd parity, queues good
// scancodes in a small FIFO and tracks make/break state for the key lookup stage.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   ps2_clk       PS/2 clock from device (asynchronous)
//   ps2_data      PS/2 data from device (asynchronous)
//   rd_en         pop the FIFO head (ignored while ready=0)
//   ovf_clr       clear the sticky overflow flag
//   data          FIFO head scancode (combinational read)
//   ready         FIFO non-empty
//   overflow      sticky: a valid frame was dropped on a full FIFO
//   frame_err     one-cycle pulse on a malformed frame
//   cur_key       last make code received
//   key_down      cur_key currently held
//   press_cnt     count of distinct key presses (wraps)
module ps2_keyboard_rx #(
    parameter int unsigned FIFO_AW = 3,
    parameter int unsigned TIMEOUT = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    input  logic       ovf_clr,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err,
    output logic [7:0] cur_key,
    output logic       key_down,
    output logic [7:0] press_cnt
);

    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

    // ---------------------------------------------------------------- synchronizers
    logic [2:0] ps2_clk_q;
    logic [1:0] ps2_data_q;
    logic       sample;
    logic       data_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_clk_q  <= 3'b111;
            ps2_data_q <= 2'b11;
        end else begin
            ps2_clk_q  <= {ps2_clk_q[1:0], ps2_clk};
            ps2_data_q <= {ps2_data_q[0], ps2_data};
        end
    end

    assign sample   = ps2_clk_q[2] & ~ps2_clk_q[1];
    assign data_bit = ps2_data_q[1];

    // ---------------------------------------------------------------- frame capture
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       shift_q, shift_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic             push_q, push_d;
    logic [7:0]       code_q, code_d;
    logic             frame_err_q, frame_err_d;
    logic             frame_ok;

    // Bits enter at the top, so after ten samples shift_q[0] holds the start bit.
    assign frame_ok = ~shift_q[0] & data_bit & (^shift_q[9:1]);

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        idle_d      = idle_q;
        push_d      = 1'b0;
        code_d      = code_q;
        frame_err_d = 1'b0;
        if (sample) begin
            idle_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (frame_ok) begin
                    push_d = 1'b1;
                    code_d = shift_q[8:1];
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                shift_d   = {data_bit, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            // Abandon a stalled partial frame so the next start bit realigns.
            if (idle_q == IdleW'(TIMEOUT)) begin
                bit_cnt_d = 4'd0;
                idle_d    = '0;
            end else begin
                idle_d = idle_q + IdleW'(1);
            end
        end else begin
            idle_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q   <= 4'd0;
            shift_q     <= 10'd0;
            idle_q      <= '0;
            push_q      <= 1'b0;
            code_q      <= 8'd0;
            frame_err_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            idle_q      <= idle_d;
            push_q      <= push_d;
            code_q      <= code_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;

    // ---------------------------------------------------------------- FIFO
    logic [7:0]         mem [Depth];
    logic [FIFO_AW-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [FIFO_AW-1:0] w_ptr_inc;
    logic               full;
    logic               do_push;
    logic               do_pop;
    logic               overflow_q, overflow_d;

    assign w_ptr_inc = w_ptr_q + FIFO_AW'(1);
    // Full is judged on pre-pop pointers, so a concurrent pop does not make room.
    assign full      = (w_ptr_inc == r_ptr_q);
    assign ready     = (w_ptr_q != r_ptr_q);
    assign do_push   = push_q & ~full;
    assign do_pop    = rd_en & ready;

    always_comb begin
        w_ptr_d    = do_push ? w_ptr_inc : w_ptr_q;
        r_ptr_d    = do_pop ? (r_ptr_q + FIFO_AW'(1)) : r_ptr_q;
        overflow_d = overflow_q;
        if (push_q && full) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr_q    <= '0;
            r_ptr_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            w_ptr_q    <= w_ptr_d;
            r_ptr_q    <= r_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[w_ptr_q] <= code_q;
        end
    end

    assign data     = mem[r_ptr_q];
    assign overflow = overflow_q;

    // ---------------------------------------------------------------- key tracker
    typedef enum logic [0:0] {StIdle, StBreak} trk_state_e;

    trk_state_e state_q, state_d;
    logic [7:0] cur_key_q, cur_key_d;
    logic       key_down_q, key_down_d;
    logic [7:0] press_cnt_q, press_cnt_d;

    always_comb begin
        state_d     = state_q;
        cur_key_d   = cur_key_q;
        key_down_d  = key_down_q;
        press_cnt_d = press_cnt_q;
        if (push_q) begin
            case (state_q)
                StIdle: begin
                    if (code_q == 8'hF0) begin
                        state_d = StBreak;
                    end else if (code_q != 8'hE0) begin
                        cur_key_d  = code_q;
                        key_down_d = 1'b1;
                        // Typematic repeats of the held key are not new presses.
                        if (!key_down_q || (code_q != cur_key_q)) begin
                            press_cnt_d = press_cnt_q + 8'd1;
                        end
                    end
                end
                StBreak: begin
                    if (code_q != 8'hE0) begin
                        if (code_q == cur_key_q) begin
                            key_down_d = 1'b0;
                        end
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cur_key_q   <= 8'd0;
            key_down_q  <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cur_key_q   <= cur_key_d;
            key_down_q  <= key_down_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign cur_key   = cur_key_q;
    assign key_down  = key_down_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: drives PS/2 frames bit by bit and checks the FIFO,
// error pulse, overflow and key-tracker outputs against hand-computed values.
module tb_ps2_keyboard_rx;

    localparam int unsigned FifoAw  = 3;
    localparam int unsigned Timeout = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;
    logic [7:0] cur_key;
    logic       key_down;
    logic [7:0] press_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int err_cycles  = 0;
    int err_rises   = 0;
    logic err_prev  = 1'b0;

    ps2_keyboard_rx #(
        .FIFO_AW(FifoAw),
        .TIMEOUT(Timeout)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rd_en    (rd_en),
        .ovf_clr  (ovf_clr),
        .data     (data),
        .ready    (ready),
        .overflow (overflow),
        .frame_err(frame_err),
        .cur_key  (cur_key),
        .key_down (key_down),
        .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    // Count high cycles and rising edges of frame_err to prove single-cycle pulses.
    always @(negedge clk) begin
        if (frame_err) err_cycles <= err_cycles + 1;
        if (frame_err && !err_prev) err_rises <= err_rises + 1;
        err_prev <= frame_err;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_clks(4);
        ps2_clk = 1'b0;
        wait_clks(8);
        ps2_clk = 1'b1;
        wait_clks(4);
    endtask

    task automatic send_frame(input logic [7:0] code, input bit flip_par, input bit bad_stop);
        logic [10:0] f;
        f = {~bad_stop, (~^code) ^ flip_par, code, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        wait_clks(4);
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) ps2_bit((i == 0) ? 1'b0 : 1'b1);
        ps2_data = 1'b1;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        wait_clks(1);
        rd_en = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, data, exp);
        pop();
    endtask

    initial begin
        // Reset state
        wait_clks(3);
        check("rst_ready", ready, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_cur_key", cur_key, 0);
        check("rst_key_down", key_down, 0);
        check("rst_press_cnt", press_cnt, 0);
        rst = 1'b0;
        wait_clks(4);

        // Single make code
        send_frame(8'h1C, 0, 0);
        check("t1_ready", ready, 1);
        check("t1_data", data, 8'h1C);
        check("t1_cur_key", cur_key, 8'h1C);
        check("t1_key_down", key_down, 1);
        check("t1_press_cnt", press_cnt, 1);
        pop();
        check("t1_ready_after_pop", ready, 0);

        // Typematic repeats then break
        send_frame(8'h1C, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        check("t2_press_cnt", press_cnt, 1);
        check("t2_key_down", key_down, 0);
        check("t2_cur_key", cur_key, 8'h1C);
        pop_check("t2_rd0", 8'h1C);
        pop_check("t2_rd1", 8'h1C);
        pop_check("t2_rd2", 8'h1C);
        pop_check("t2_rd3", 8'hF0);
        pop_check("t2_rd4", 8'h1C);
        check("t2_empty", ready, 0);

        // Bad parity, then bad stop bit
        send_frame(8'h1C, 1, 0);
        send_frame(8'h2A, 0, 1);
        check("t3_err_rises", 8'(err_rises), 2);
        check("t3_err_cycles", 8'(err_cycles), 2);
        check("t3_ready", ready, 0);
        check("t3_cur_key", cur_key, 8'h1C);
        check("t3_key_down", key_down, 0);
        check("t3_press_cnt", press_cnt, 1);

        // Fill past capacity
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 0);
        check("t4_overflow", overflow, 1);
        check("t4_press_cnt", press_cnt, 9);
        check("t4_cur_key", cur_key, 8'h08);
        for (int i = 1; i <= 7; i++) pop_check("t4_rd", 8'(i));
        check("t4_empty", ready, 0);
        check("t4_overflow_sticky", overflow, 1);
        ovf_clr = 1'b1;
        wait_clks(1);
        ovf_clr = 1'b0;
        check("t4_overflow_clr", overflow, 0);

        // Timeout discards a partial frame
        send_partial(5);
        wait_clks(Timeout + 5);
        check("t5_ready_idle", ready, 0);
        send_frame(8'h32, 0, 0);
        check("t5_ready", ready, 1);
        check("t5_data", data, 8'h32);
        check("t5_press_cnt", press_cnt, 10);
        check("t5_err_cycles", 8'(err_cycles), 2);
        pop();

        // Asynchronous reset mid-frame
        send_frame(8'h11, 0, 0);
        check("t6_ready_pre", ready, 1);
        send_partial(6);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_ready", ready, 0);
        check("t6_rst_overflow", overflow, 0);
        check("t6_rst_frame_err", frame_err, 0);
        check("t6_rst_cur_key", cur_key, 0);
        check("t6_rst_key_down", key_down, 0);
        check("t6_rst_press_cnt", press_cnt, 0);
        wait_clks(3);
        rst = 1'b0;
        wait_clks(3);
        send_frame(8'h45, 0, 0);
        check("t6_ready", ready, 1);
        check("t6_data", data, 8'h45);
        check("t6_cur_key", cur_key, 8'h45);
        check("t6_press_cnt", press_cnt, 1);
        check("t6_err_cycles", 8'(err_cycles), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
